// File: rtl/sram_port_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_port_ctrl_pkg
// Shared constants and types for the OpenRAM 1RW+1R 32x1024 port controller.
//   ADDR_WIDTH / DATA_WIDTH / NUM_WMASKS : macro geometry
//   FIFO_DEPTH                           : read response buffer depth
//   INIT_LAST_ADDR                       : final address of the zero-fill sweep
//   ctrl_state_e                         : controller FSM state
//   req_t                                : one host request (we, be, addr, wdata)
// -----------------------------------------------------------------------------
package sram_port_ctrl_pkg;

  localparam int ADDR_WIDTH = 10;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_WMASKS = DATA_WIDTH / 8;
  localparam int FIFO_DEPTH = 2;

  localparam logic [ADDR_WIDTH-1:0] INIT_LAST_ADDR = '1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

  typedef struct packed {
    logic                  we;
    logic [NUM_WMASKS-1:0] be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// -----------------------------------------------------------------------------
// sram_rsp_fifo
// Two-entry read-response FIFO. Head data is shown combinationally.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   push_i, push_data_i : write one word (ignored when full)
//   pop_i           : drop the head word (ignored when empty)
//   pop_data_o      : head word
//   count_o         : number of stored words (0..2)
// Simultaneous push and pop keeps the count and preserves order.
// -----------------------------------------------------------------------------
module sram_rsp_fifo
  import sram_port_ctrl_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic [1:0]            count_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push_i && (count_q != 2'(FIFO_DEPTH));
  assign do_pop  = pop_i && (count_q != 2'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/sram_port_ctrl.sv
// -----------------------------------------------------------------------------
// sram_port_ctrl
// Host-side controller for port 0 of the OpenRAM 1RW+1R 32x1024 macro.
// Port 1 is parked (csb1=1, addr1=0).
//
// Build option: SRAM_PORT_CTRL_INIT_EN
//   defined   : after reset an INIT sweep writes zero to all 1024 words
//               (one per cycle, full mask) before requests are accepted.
//   undefined : controller comes out of reset directly in RUN.
//
// Ports
//   clk_i, rst_ni                  : clock, asynchronous active-low reset
//   req_valid_i / req_ready_o      : request handshake
//   req_we_i, req_be_i, req_addr_i, req_wdata_i : request payload
//   rsp_valid_o / rsp_ready_i      : read-response handshake
//   rsp_rdata_o                    : read data (FIFO head)
//   sram_csb0_o..sram_din0_o       : macro port 0 drive (csb/web active-low)
//   sram_dout0_i                   : macro port 0 read data
//   sram_csb1_o, sram_addr1_o      : macro port 1, held idle
//   init_done_o                    : high while in RUN
//   state_o                        : current FSM state (debug)
//
// Handshakes: a transfer happens at a posedge where valid and ready are both
// high. Requests: valid/payload must hold until accepted; ready may depend on
// rsp_ready_i combinationally (a pop in the same cycle frees a credit).
// Responses: rsp_rdata_o is stable while rsp_valid_o is high and not popped.
// -----------------------------------------------------------------------------
module sram_port_ctrl
  import sram_port_ctrl_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [NUM_WMASKS-1:0] req_be_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  sram_csb0_o,
  output logic                  sram_web0_o,
  output logic [NUM_WMASKS-1:0] sram_wmask0_o,
  output logic [ADDR_WIDTH-1:0] sram_addr0_o,
  output logic [DATA_WIDTH-1:0] sram_din0_o,
  input  logic [DATA_WIDTH-1:0] sram_dout0_i,
  output logic                  sram_csb1_o,
  output logic [ADDR_WIDTH-1:0] sram_addr1_o,
  output logic                  init_done_o,
  output ctrl_state_e           state_o
);

  req_t        req;
  ctrl_state_e state_q;
  logic        run;
  logic        accept;
  logic        rsp_pop;
  logic        inflight_q;
  logic [1:0]  fifo_count;

  assign req = {req_we_i, req_be_i, req_addr_i, req_wdata_i};

`ifdef SRAM_PORT_CTRL_INIT_EN
  ctrl_state_e           state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      // The counter wraps back to 0 on the last sweep write.
      if (state_q == ST_INIT) begin
        init_cnt_q <= init_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == ST_INIT) && (init_cnt_q == INIT_LAST_ADDR)) begin
      state_d = ST_RUN;
    end
  end
`else
  assign state_q = ST_RUN;
`endif

  assign run     = (state_q == ST_RUN);
  assign rsp_pop = rsp_valid_o && rsp_ready_i;

  // Credit: buffered words plus the read still in the macro must leave room,
  // unless the head leaves this cycle.
  assign req_ready_o = run && (((fifo_count + {1'b0, inflight_q}) < 2'd2) || rsp_pop);
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    sram_csb0_o   = 1'b1;
    sram_web0_o   = 1'b1;
    sram_wmask0_o = '0;
    sram_addr0_o  = '0;
    sram_din0_o   = '0;
    if (accept) begin
      sram_csb0_o  = 1'b0;
      sram_web0_o  = !req.we;
      sram_addr0_o = req.addr;
      if (req.we) begin
        sram_wmask0_o = req.be;
        sram_din0_o   = req.wdata;
      end
    end
`ifdef SRAM_PORT_CTRL_INIT_EN
    // Sweep drive is suppressed while reset is held so the port is idle.
    if ((state_q == ST_INIT) && rst_ni) begin
      sram_csb0_o   = 1'b0;
      sram_web0_o   = 1'b0;
      sram_wmask0_o = '1;
      sram_addr0_o  = init_cnt_q;
      sram_din0_o   = '0;
    end
`endif
  end

  // A read accepted at one edge has its data on dout0 at the next edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= accept && !req.we;
    end
  end

  sram_rsp_fifo u_rsp_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (inflight_q),
    .push_data_i (sram_dout0_i),
    .pop_i       (rsp_pop),
    .pop_data_o  (rsp_rdata_o),
    .count_o     (fifo_count)
  );

  assign rsp_valid_o  = (fifo_count != 2'd0);
  assign sram_csb1_o  = 1'b1;
  assign sram_addr1_o = '0;
  assign init_done_o  = run;
  assign state_o      = state_q;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_port_ctrl
// Bench for sram_port_ctrl with a behavioural model of the SRAM macro port 0.
// Honours SRAM_PORT_CTRL_INIT_EN the same way as the design.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sram_port_ctrl;
  import sram_port_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic                  req_valid_i, req_ready_o, req_we_i;
  logic [NUM_WMASKS-1:0] req_be_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic                  rsp_valid_o, rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  sram_csb0_o, sram_web0_o;
  logic [NUM_WMASKS-1:0] sram_wmask0_o;
  logic [ADDR_WIDTH-1:0] sram_addr0_o;
  logic [DATA_WIDTH-1:0] sram_din0_o;
  logic [DATA_WIDTH-1:0] sram_dout0_i;
  logic                  sram_csb1_o;
  logic [ADDR_WIDTH-1:0] sram_addr1_o;
  logic                  init_done_o;
  ctrl_state_e           state_o;

  sram_port_ctrl dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_we_i      (req_we_i),
    .req_be_i      (req_be_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_rdata_o   (rsp_rdata_o),
    .sram_csb0_o   (sram_csb0_o),
    .sram_web0_o   (sram_web0_o),
    .sram_wmask0_o (sram_wmask0_o),
    .sram_addr0_o  (sram_addr0_o),
    .sram_din0_o   (sram_din0_o),
    .sram_dout0_i  (sram_dout0_i),
    .sram_csb1_o   (sram_csb1_o),
    .sram_addr1_o  (sram_addr1_o),
    .init_done_o   (init_done_o),
    .state_o       (state_o)
  );

  // ---------------- SRAM macro model ----------------
  function automatic logic [31:0] pre(int i);
    return 32'hA5A50000 + i;
  endfunction

  logic [31:0] mem [1024];
  bit          preloaded = 1'b0;
  int          wr_count = 0;
  int          bad_init_wr = 0;

  always @(posedge clk_i) begin
    if (!preloaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pre(i);
      preloaded <= 1'b1;
    end
    if (!sram_csb0_o) begin
      if (!sram_web0_o) begin
        wr_count++;
        if (!init_done_o && (sram_din0_o != 32'd0 || sram_wmask0_o != 4'hF)) bad_init_wr++;
        for (int b = 0; b < 4; b++)
          if (sram_wmask0_o[b]) mem[sram_addr0_o][b*8 +: 8] <= sram_din0_o[b*8 +: 8];
      end else begin
        sram_dout0_i <= mem[sram_addr0_o];
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          rsp_cyc_q[$];
  logic [31:0] ref_mem [1024];
  int          acc_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni && rsp_valid_o && rsp_ready_i) begin
      rsp_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got %h expected no response", rsp_rdata_o);
      end else begin
        chk("rsp_data", rsp_rdata_o, exp_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] init_val(int i);
`ifdef SRAM_PORT_CTRL_INIT_EN
    return (i >= 0) ? 32'd0 : 32'd0;
`else
    return pre(i);
`endif
  endfunction

  // ---------------- driver ----------------
  // Called with the bench positioned just after a posedge; returns 1ns after
  // the accepting posedge so consecutive calls issue on consecutive cycles.
  task automatic do_req(input logic we, input logic [3:0] be, input logic [9:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp, input bit use_exp);
    int waited = 0;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_be_i    = be;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    @(negedge clk_i);
    while (!req_ready_o && waited < 64) begin
      waited++;
      @(negedge clk_i);
    end
    if (!req_ready_o) begin
      checks++;
      errors++;
      $display("FAIL req_accept_timeout addr %0d: ready 0 expected 1", addr);
      req_valid_i = 1'b0;
      return;
    end
    acc_cyc = cyc;
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[addr][b*8 +: 8] = wdata[b*8 +: 8];
    end else begin
      exp_q.push_back(use_exp ? exp : ref_mem[addr]);
    end
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 32) begin
      n++;
      @(posedge clk_i);
    end
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  task automatic wait_init(input string name);
`ifdef SRAM_PORT_CTRL_INIT_EN
    int n = 0;
    int ready_seen = 0;
    int base_wr = wr_count;
    int base_bad = bad_init_wr;
    @(negedge clk_i);
    while (!init_done_o && n < 1100) begin
      n++;
      if (req_ready_o) ready_seen++;
      @(negedge clk_i);
    end
    chk({name, "_cycles"}, n, 1024);
    chk({name, "_writes"}, wr_count - base_wr, 1024);
    chk({name, "_bad_writes"}, bad_init_wr - base_bad, 0);
    chk({name, "_ready_low"}, ready_seen, 0);
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
`else
    @(negedge clk_i);
    chk({name, "_done"}, init_done_o, 1'b1);
`endif
    chk({name, "_state"}, 32'(state_o), 32'(ST_RUN));
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_port_idle(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid_o, 1'b0);
    chk({tag, "_rsp_rdata"}, rsp_rdata_o, 32'd0);
    chk({tag, "_csb0"}, sram_csb0_o, 1'b1);
    chk({tag, "_web0"}, sram_web0_o, 1'b1);
    chk({tag, "_wmask0"}, sram_wmask0_o, 4'h0);
    chk({tag, "_addr0"}, sram_addr0_o, 10'd0);
    chk({tag, "_din0"}, sram_din0_o, 32'd0);
    chk({tag, "_csb1"}, sram_csb1_o, 1'b1);
    chk({tag, "_addr1"}, sram_addr1_o, 10'd0);
`ifdef SRAM_PORT_CTRL_INIT_EN
    chk({tag, "_ready"}, req_ready_o, 1'b0);
    chk({tag, "_init_done"}, init_done_o, 1'b0);
`else
    chk({tag, "_ready"}, req_ready_o, 1'b1);
    chk({tag, "_init_done"}, init_done_o, 1'b1);
`endif
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] iv;
    int          first_acc;
    int          gaps;
    int          cnt;
    bit          rnd_done;

    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_be_i    = '0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    rsp_ready_i = 1'b1;
    rst_ni      = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = pre(i);

    repeat (3) @(posedge clk_i);
    #1;
    chk_port_idle("reset");

    rst_ni = 1'b1;
    wait_init("init");

    // Table phase: masked write, zero mask, RAW, init contents.
    iv = init_val(10);
    vecs.push_back('{1'b1, 4'hF,    10'd3,    32'hDEADBEEF, 32'd0});
    vecs.push_back('{1'b1, 4'b0001, 10'd3,    32'h00000011, 32'd0});
    vecs.push_back('{1'b0, 4'h0,    10'd3,    32'd0,        32'hDEADBE11});
    vecs.push_back('{1'b1, 4'hF,    10'd1023, 32'h12345678, 32'd0});
    vecs.push_back('{1'b0, 4'h0,    10'd1023, 32'd0,        32'h12345678});
    vecs.push_back('{1'b1, 4'h0,    10'd7,    32'hFFFFFFFF, 32'd0});
    vecs.push_back('{1'b0, 4'h0,    10'd7,    32'd0,        init_val(7)});
    vecs.push_back('{1'b0, 4'h0,    10'd5,    32'd0,        init_val(5)});
    vecs.push_back('{1'b1, 4'b1010, 10'd10,   32'hAABBCCDD, 32'd0});
    vecs.push_back('{1'b0, 4'h0,    10'd10,   32'd0,        {8'hAA, iv[23:16], 8'hCC, iv[7:0]}});
    for (int i = 0; i < vecs.size(); i++)
      do_req(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, vecs[i].exp, 1'b1);
    drain("table_drain");

    // Back-to-back reads 0..7.
    repeat (3) @(posedge clk_i);
    #1;
    rsp_cyc_q.delete();
    first_acc = 0;
    for (int a = 0; a < 8; a++) begin
      do_req(1'b0, 4'h0, 10'(a), 32'd0, 32'd0, 1'b0);
      if (a == 0) first_acc = acc_cyc;
    end
    repeat (4) @(posedge clk_i);
    #1;
    chk("b2b_count", rsp_cyc_q.size(), 8);
    if (rsp_cyc_q.size() == 8) begin
      chk("b2b_latency", rsp_cyc_q[0] - first_acc, 2);
      gaps = 0;
      for (int i = 1; i < 8; i++) if (rsp_cyc_q[i] != rsp_cyc_q[i-1] + 1) gaps++;
      chk("b2b_gaps", gaps, 0);
    end

    // Backpressure: two reads fit, the third must wait.
    rsp_ready_i = 1'b0;
    do_req(1'b0, 4'h0, 10'd20, 32'd0, 32'd0, 1'b0);
    do_req(1'b0, 4'h0, 10'd21, 32'd0, 32'd0, 1'b0);
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_addr_i  = 10'd22;
    cnt = 0;
    repeat (4) begin
      @(negedge clk_i);
      if (req_ready_o) cnt++;
    end
    chk("bp_ready_low", cnt, 0);
    chk("bp_rsp_valid", rsp_valid_o, 1'b1);
    chk("bp_pending", exp_q.size(), 2);
    @(posedge clk_i);
    #1;
    rsp_ready_i = 1'b1;
    do_req(1'b0, 4'h0, 10'd22, 32'd0, 32'd0, 1'b0);
    do_req(1'b0, 4'h0, 10'd23, 32'd0, 32'd0, 1'b0);
    drain("bp_drain");

    // Random traffic with random response backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 60; k++)
          do_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 10'($urandom_range(0, 15)),
                 $urandom, 32'd0, 1'b0);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk_i);
          #1;
          rsp_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    rsp_ready_i = 1'b1;
    drain("rnd_drain");

    // Reset with two responses pending.
    rsp_ready_i = 1'b0;
    do_req(1'b0, 4'h0, 10'd1, 32'd0, 32'd0, 1'b0);
    do_req(1'b0, 4'h0, 10'd2, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("mid_pending_valid", rsp_valid_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk_port_idle("mid_reset");
    exp_q.delete();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    rsp_ready_i = 1'b1;
    wait_init("reinit");
    do_req(1'b0, 4'h0, 10'd3, 32'd0, 32'd0, 1'b0);
    do_req(1'b0, 4'h0, 10'd1023, 32'd0, 32'd0, 1'b0);
    drain("post_reset_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
